switch_output_arbiter: RTL and testbench
========================================

// Module: switch_output_arbiter
// PURPOSE
//   Per-output-port packet scheduler for the 4-port switch. One instance sits
//   in front of each egress port. It shares that egress between the ingress
//   port FIFOs whose head packets target it.
//   Arbitration is round-robin, at packet granularity. A grant is held from the
//   first beat to EOP, so packets never interleave on an output.
//   A beat watchdog releases the output if a packet runs too long.
// PARAMETERS
//   N_PORTS        4   number of requesters (ingress FIFOs)
//   DATA_W         8   beat width in bits
//   MAX_PKT_BEATS  16  beats allowed per packet before forced release (>=2)
// PORTS
//   clk          in   1             single clock; all state on posedge clk
//   rst          in   1             asynchronous, active-high reset
//   req_valid    in   N_PORTS       requester i presents a beat for this output
//   req_data     in   N_PORTS*DATA_W  beat from requester i, slice [i*DATA_W +: DATA_W]
//   req_eop      in   N_PORTS       beat from requester i is last of its packet
//   req_ready    out  N_PORTS       pop strobe to requester i FIFO
//   out_valid    out  1             beat valid toward egress
//   out_data     out  DATA_W        muxed beat
//   out_eop      out  1             muxed EOP
//   out_ready    in   1             egress accepts beat
//   grant        out  N_PORTS       one-hot current owner; 0 when idle
//   busy         out  1             high in XFER
//   err_overrun  out  1             1-cycle pulse on watchdog release
// BEHAVIOUR
//   Reset (async assert, sync release) forces:
//     state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, err_overrun=0.
//     Hence out_valid=0, req_ready=0 and busy=0.
//   FSM IDLE:
//     - If |req_valid, the winner is the first i with req_valid[i] set, scanning
//       rr_ptr, rr_ptr+1, ... mod N_PORTS.
//     - Register grant<=onehot(winner), beat_cnt<=0, state<=XFER.
//     - Latency is 1 cycle from request to grant.
//   FSM XFER (owner g):
//     - out_valid = req_valid[g]; out_data/out_eop = requester g slice.
//     - req_ready[g] = out_ready; req_ready of every other requester is 0.
//     - A transfer (xfer) occurs when out_valid & out_ready.
//   Per xfer:
//     - beat_cnt++.
//     - If req_eop[g], or beat_cnt==MAX_PKT_BEATS-1: state<=IDLE, grant<=0,
//       rr_ptr<=(g+1) mod N_PORTS.
//   Watchdog:
//     - When the watchdog term fires without EOP, err_overrun pulses in the
//       following cycle.
//     - The remaining beats of that packet re-arbitrate later as a new packet.
//   Inter-packet gap: exactly 1 IDLE cycle after every EOP; no back-to-back grants.
//   Owner stall: if req_valid[g] drops mid-packet, the grant is held and
//   out_valid=0. There is no timeout on stall.
//   Backpressure:
//     - While out_ready=0, req_ready=0 and nothing pops.
//     - out_data mirrors the stable FIFO head.
//   Non-owner requests: ignored until IDLE; they are never lost, only delayed.
//     Worst-case wait is (N_PORTS-1) packets.
//   Width rules:
//     - beat_cnt is $clog2(MAX_PKT_BEATS) bits and never wraps; the watchdog
//       releases first.
//     - rr_ptr is $clog2(N_PORTS) bits, mod-N wrap.
//   Reset mid-packet:
//     - Outputs drop immediately (async).
//     - The partial packet stays in the ingress FIFO tail; discarding it is
//       the ingress side's responsibility.
// STRUCTURE
//   switch_arb_pkg:
//     - typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_e
//     - localparam N_PORTS = 4
//     - function onehot2idx
//   Sub-module rr_priority_picker: combinational.
//     - Inputs req[N_PORTS] and ptr; outputs winner index and any_req.
//     - Also reused by the crossbar config block.
//   The top holds the FSM, grant/ptr/beat_cnt regs and the output mux.
// TESTING
//   1. Only req 0 holds a 3-beat pkt (A1,A2,A3 eop), out_ready=1:
//      grant=0001 at cycle+1; A1..A3 out on consecutive cycles.
//      Then grant=0 and rr_ptr=1.
//   2. All 4 reqs with continuous 1-beat pkts after reset:
//      grant order 0,1,2,3,0,...
//      Beats every 2nd cycle, 1 IDLE gap between each.
//   3. Req 1 mid 4-beat pkt, out_ready=0 for 5 cycles:
//      req_ready=0 and out_data held throughout. All 4 beats are delivered,
//      none duplicated.
//   4. Req 2 sends a 20-beat pkt, MAX_PKT_BEATS=16:
//      release after beat 16; err_overrun=1 for exactly one cycle; rr_ptr=3.
//      Beats 17-20 are re-granted later.
//   5. rr_ptr=2, req 1 and req 3 raised in the same cycle:
//      3 wins; 1 is granted after 3's EOP.
//   6. rst raised mid-packet:
//      grant=0 and out_valid=0 before the next clk edge.
//      After release, the first grant goes to the lowest requesting index
//      (rr_ptr=0).

Source files
------------

// File: rtl/switch_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : switch_arb_pkg
// Purpose : Shared types, constants and helpers for the per-egress packet
//           arbiter and the crossbar configuration logic.
// Contents: arb_state_e  - arbiter FSM state encoding
//           N_PORTS      - number of switch ports
//           IDX_W        - width of a port index
//           onehot2idx() - one-hot port vector to binary index
// Revision: 1.0 - initial release
// ============================================================================
package switch_arb_pkg;

  localparam int N_PORTS = 4;
  localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Returns the index of the set bit; an all-zero vector maps to index 0.
  function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_PORTS-1:0] i_oh);
    logic [IDX_W-1:0] w_idx;
    w_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (i_oh[i]) begin
        w_idx = IDX_W'(i);
      end
    end
    return w_idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_output_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_priority_picker
// Purpose : Combinational round-robin picker. Scans the request vector
//           starting at i_ptr and wrapping modulo N, and reports the first
//           requester found.
// Ports   : i_req      [N-1:0]      request vector
//           i_ptr      [PTR_W-1:0]  index with highest priority this round
//           o_winner   [PTR_W-1:0]  selected index (i_ptr when nothing requests)
//           o_any_req               at least one request is active
// Revision: 1.0 - initial release
// ============================================================================
import switch_arb_pkg::*;

module rr_priority_picker #(
  parameter int N     = switch_arb_pkg::N_PORTS,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_winner,
  output logic             o_any_req
);

  // Walk the offsets from farthest to nearest so that the requester closest
  // to the pointer (in wrap order) is the last assignment and therefore wins.
  always_comb begin
    o_winner  = i_ptr;
    o_any_req = |i_req;
    for (int off = N - 1; off >= 0; off--) begin
      if (i_req[(int'(i_ptr) + off) % N]) begin
        o_winner = PTR_W'((int'(i_ptr) + off) % N);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : switch_output_arbiter
// Purpose : Per-egress packet scheduler. Shares one output port between the
//           ingress FIFOs whose head packets target it, round-robin at packet
//           granularity. A grant is held from the first beat to EOP so packets
//           never interleave; a beat watchdog forces release of overlong
//           packets and flags it on err_overrun.
// Ports   : clk, rst                   clock, async active-high reset
//           req_valid/req_eop [N]      per-requester head beat valid / last
//           req_data [N*DATA_W]        per-requester head beat
//           req_ready [N]              pop strobe to the owning FIFO
//           out_valid/out_data/out_eop muxed beat toward egress
//           out_ready                  egress accepts beat
//           grant [N]                  one-hot owner, 0 when idle
//           busy                       a packet is in flight
//           err_overrun                one-cycle pulse after watchdog release
// Revision: 1.0 - initial release
// ============================================================================
import switch_arb_pkg::*;

module switch_output_arbiter #(
  parameter int N_PORTS       = switch_arb_pkg::N_PORTS,
  parameter int DATA_W        = 8,
  parameter int MAX_PKT_BEATS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_valid,
  input  logic [N_PORTS*DATA_W-1:0]   req_data,
  input  logic [N_PORTS-1:0]          req_eop,
  output logic [N_PORTS-1:0]          req_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_eop,
  input  logic                        out_ready,
  output logic [N_PORTS-1:0]          grant,
  output logic                        busy,
  output logic                        err_overrun
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = $clog2(MAX_PKT_BEATS);

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(MAX_PKT_BEATS - 1);
  localparam logic [PTR_W-1:0] c_LAST_IDX = PTR_W'(N_PORTS - 1);

  arb_state_e          r_state,       w_state_nxt;
  logic [N_PORTS-1:0]  r_grant,       w_grant_nxt;
  logic [PTR_W-1:0]    r_rr_ptr,      w_rr_ptr_nxt;
  logic [CNT_W-1:0]    r_beat_cnt,    w_beat_cnt_nxt;
  logic                r_err_overrun, w_err_overrun_nxt;

  logic [PTR_W-1:0]    w_owner;
  logic [PTR_W-1:0]    w_winner;
  logic                w_any_req;
  logic                w_xfer;
  logic                w_eop;
  logic                w_wd_hit;

  rr_priority_picker #(
    .N     (N_PORTS),
    .PTR_W (PTR_W)
  ) u_picker (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_owner = onehot2idx(r_grant);

  // Output mux: only the owner is visible and only the owner can be popped.
  // req_ready follows out_ready directly so a stalled egress never pops.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_eop   = 1'b0;
    req_ready = '0;
    if (r_state == ARB_XFER) begin
      out_valid          = req_valid[w_owner];
      out_data           = req_data[w_owner*DATA_W +: DATA_W];
      out_eop            = req_eop[w_owner];
      req_ready[w_owner] = out_ready;
    end
  end

  assign w_xfer   = out_valid & out_ready;
  assign w_eop    = req_eop[w_owner];
  assign w_wd_hit = (r_beat_cnt == c_LAST_CNT);

  // Next-state logic. The release path always returns to IDLE, which gives the
  // mandatory single-cycle gap before the next grant is registered.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_beat_cnt_nxt    = r_beat_cnt;
    w_err_overrun_nxt = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = ARB_XFER;
          w_grant_nxt    = N_PORTS'(1) << w_winner;
          w_beat_cnt_nxt = '0;
        end
      end
      ARB_XFER: begin
        if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          if (w_eop || w_wd_hit) begin
            w_state_nxt       = ARB_IDLE;
            w_grant_nxt       = '0;
            // Cleared here so the counter never wraps on a watchdog release.
            w_beat_cnt_nxt    = '0;
            w_rr_ptr_nxt      = (w_owner == c_LAST_IDX) ? '0 : (w_owner + PTR_W'(1));
            w_err_overrun_nxt = w_wd_hit & ~w_eop;
          end
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_beat_cnt    <= '0;
      r_err_overrun <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_beat_cnt    <= w_beat_cnt_nxt;
      r_err_overrun <= w_err_overrun_nxt;
    end
  end

  assign grant       = r_grant;
  assign busy        = (r_state == ARB_XFER);
  assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire

// File: tb/tb_switch_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_output_arbiter
// Purpose : Self-checking bench for switch_output_arbiter. Ingress FIFOs are
//           modelled as queues; expected beats and grant owners are queued as
//           stimulus is issued and a monitor compares at every output event.
// Revision: 1.0 - initial release
// ============================================================================
module tb_switch_output_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_eop;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_eop;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic            err_overrun;

  always #5 clk = ~clk;

  switch_output_arbiter #(
    .N_PORTS       (N),
    .DATA_W        (DW),
    .MAX_PKT_BEATS (MAXB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_eop     (req_eop),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_eop     (out_eop),
    .out_ready   (out_ready),
    .grant       (grant),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          eop;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          eop;
    logic          wd;
  } exp_t;

  beat_t fifo [N][$];
  exp_t  sb [$];
  int    exp_grant [$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int xfer_cnt = 0;
  int last_xfer_cyc = 0;
  logic have_prev = 1'b0;
  logic gap_en    = 1'b0;
  logic ovr_due   = 1'b0;
  logic [N-1:0] prev_grant = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void refresh();
    for (int i = 0; i < N; i++) begin
      if (fifo[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = fifo[i][0].data;
        req_eop[i]           = fifo[i][0].eop;
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_eop[i]           = 1'b0;
      end
    end
  endfunction

  // Load a packet into ingress FIFO p: data values base+1 .. base+n, EOP on last.
  task automatic push_pkt(input int p, input logic [DW-1:0] base, input int n);
    for (int k = 1; k <= n; k++) begin
      fifo[p].push_back('{data: base + DW'(k), eop: (k == n)});
    end
    refresh();
  endtask

  // Expect beats base+first .. base+last; eop_last marks the final one as EOP,
  // wd_last marks the final one as a watchdog release.
  task automatic exp_beats(input logic [DW-1:0] base, input int first, input int last,
                           input logic eop_last, input logic wd_last);
    for (int k = first; k <= last; k++) begin
      sb.push_back('{data: base + DW'(k), eop: (k == last) && eop_last,
                     wd: (k == last) && wd_last});
    end
  endtask

  // FIFO model: pop whatever the DUT strobed at the edge.
  initial begin
    logic [N-1:0] pop;
    req_valid = '0;
    req_data  = '0;
    req_eop   = '0;
    forever begin
      @(negedge clk);
      pop = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (pop[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
      end
      refresh();
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    chk("err_overrun", {31'd0, err_overrun}, {31'd0, ovr_due});
    ovr_due = 1'b0;
    if (grant != '0 && prev_grant == '0) begin
      if (exp_grant.size() == 0) begin
        chk("unexpected_grant", {28'd0, grant}, 32'd0);
      end else begin
        chk("grant_owner", {28'd0, grant}, 32'd1 << exp_grant.pop_front());
      end
    end
    prev_grant = grant;
    if (out_valid && out_ready) begin
      xfer_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
        chk("beat_eop", {31'd0, out_eop}, {31'd0, e.eop});
        ovr_due = e.wd;
      end
      if (gap_en && have_prev) chk("beat_spacing", cyc - last_xfer_cyc, 2);
      have_prev     = 1'b1;
      last_xfer_cyc = cyc;
    end
  end

  task automatic wait_done(input string name, input int lim);
    int n = 0;
    while ((sb.size() != 0 || exp_grant.size() != 0 || busy || (|req_valid)) && n < lim) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drain_timeout"}, {31'd0, (n >= lim)}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_xfers(input string name, input int tgt, input int lim);
    int n = 0;
    while (xfer_cnt < tgt && n < lim) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_xfer_timeout"}, {31'd0, (n >= lim)}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    out_ready = 1'b1;
    do_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // 1: single 3-beat packet on port 0, then pointer moves to 1.
    @(posedge clk); #2;
    push_pkt(0, 8'hA0, 3);
    exp_grant.push_back(0);
    exp_beats(8'hA0, 1, 3, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_grant_pre", {28'd0, grant}, 32'd0);
    @(negedge clk);
    chk("t1_grant_lat", {28'd0, grant}, 32'h1);
    chk("t1_valid_b1", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("t1_valid_b2", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("t1_valid_b3", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("t1_grant_idle", {28'd0, grant}, 32'd0);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    wait_done("t1", 50);
    push_pkt(0, 8'hB0, 1);
    push_pkt(1, 8'hB4, 1);
    exp_grant.push_back(1);
    exp_grant.push_back(0);
    exp_beats(8'hB4, 1, 1, 1'b1, 1'b0);
    exp_beats(8'hB0, 1, 1, 1'b1, 1'b0);
    wait_done("t1_ptr", 50);

    // 2: all ports, two 1-beat packets each, strict rotation and 1-cycle gap.
    do_reset();
    @(posedge clk); #2;
    have_prev = 1'b0;
    gap_en    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < N; p++) begin
        push_pkt(p, DW'(8'h40 + 8'(p * 16 + k * 4)), 1);
      end
    end
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < N; p++) begin
        exp_grant.push_back(p);
        exp_beats(DW'(8'h40 + 8'(p * 16 + k * 4)), 1, 1, 1'b1, 1'b0);
      end
    end
    wait_done("t2", 100);
    gap_en = 1'b0;

    // 3: backpressure in the middle of a 4-beat packet on port 1.
    base = xfer_cnt;
    push_pkt(1, 8'h10, 4);
    exp_grant.push_back(1);
    exp_beats(8'h10, 1, 4, 1'b1, 1'b0);
    wait_xfers("t3", base + 2, 50);
    #2;
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("t3_stall_ready", {28'd0, req_ready}, 32'd0);
      chk("t3_stall_data", {24'd0, out_data}, 32'h13);
      chk("t3_stall_grant", {28'd0, grant}, 32'h2);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_done("t3", 50);

    // 4: 20-beat packet on port 2 trips the watchdog after beat 16; pointer
    //    moves to 3, so 3 then 1 run before the tail of port 2's packet.
    push_pkt(2, 8'h80, 20);
    exp_grant.push_back(2);
    exp_beats(8'h80, 1, 16, 1'b0, 1'b1);
    begin
      int n = 0;
      while (grant != 4'b0100 && n < 20) begin
        @(posedge clk);
        n++;
      end
      chk("t4_grant_timeout", {31'd0, (n >= 20)}, 32'd0);
    end
    #2;
    push_pkt(3, 8'hC0, 1);
    push_pkt(1, 8'hC8, 1);
    exp_grant.push_back(3);
    exp_grant.push_back(1);
    exp_grant.push_back(2);
    exp_beats(8'hC0, 1, 1, 1'b1, 1'b0);
    exp_beats(8'hC8, 1, 1, 1'b1, 1'b0);
    exp_beats(8'h80, 17, 20, 1'b1, 1'b0);
    wait_done("t4", 100);

    // 5: move pointer to 2, then ports 1 and 3 request together: 3 wins.
    push_pkt(1, 8'hD0, 1);
    exp_grant.push_back(1);
    exp_beats(8'hD0, 1, 1, 1'b1, 1'b0);
    wait_done("t5_setup", 50);
    push_pkt(1, 8'hE0, 2);
    push_pkt(3, 8'hE8, 2);
    exp_grant.push_back(3);
    exp_grant.push_back(1);
    exp_beats(8'hE8, 1, 2, 1'b1, 1'b0);
    exp_beats(8'hE0, 1, 2, 1'b1, 1'b0);
    wait_done("t5", 50);

    // 6: reset in the middle of a packet on port 0.
    base = xfer_cnt;
    push_pkt(0, 8'hF0, 4);
    exp_grant.push_back(0);
    exp_beats(8'hF0, 1, 2, 1'b0, 1'b0);
    wait_xfers("t6", base + 2, 50);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_grant", {28'd0, grant}, 32'd0);
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < N; i++) fifo[i].delete();
    refresh();
    sb.delete();
    exp_grant.delete();
    do_reset();
    push_pkt(3, 8'h30, 1);
    push_pkt(1, 8'h38, 1);
    exp_grant.push_back(1);
    exp_grant.push_back(3);
    exp_beats(8'h38, 1, 1, 1'b1, 1'b0);
    exp_beats(8'h30, 1, 1, 1'b1, 1'b0);
    wait_done("t6", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
